// File: rtl/pcie_pkg.sv
// pcie_pkg: shared constants and FSM state encoding for the pcie_recv receive path
package pcie_pkg;
    localparam int DATA_W = 6;
    localparam int LANE_DEPTH = 4;
    localparam logic [2:0] UMBRAL_DEFAULT = 3'd3;
    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE,
        ST_ERROR
    } state_t;
endpackage

// File: rtl/pcie_recv_rx_lane_fifo.sv
// rx_lane_fifo: 4-deep lane buffer with occupancy count and almost-full pause compare
module rx_lane_fifo
    import pcie_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_umbral,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_pausa
);
    logic [DATA_W-1:0] r_mem [LANE_DEPTH];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full  = r_count == 3'(LANE_DEPTH);
    assign o_empty = r_count == 3'd0;
    assign o_pausa = r_count >= i_umbral;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_rd    = i_pop && !o_empty;
    // a simultaneous read frees the slot, so a full lane may still accept
    assign w_wr    = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b0, w_wr} - {2'b0, w_rd};
        end
    end
endmodule

// File: rtl/pcie_recv.sv
// pcie_recv: two-lane receive buffer with round-robin merge, registered output and control FSM
module pcie_recv
    import pcie_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [2:0]        umbral,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              push0,
    input  logic              push1,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              pausa0,
    output logic              pausa1,
    output logic              active_out,
    output logic              idle_out,
    output logic              error_out,
    output logic [1:0]        error_id
);
    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_umbral;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_active;
    logic              r_idle;
    logic              r_error;
    logic [1:0]        r_error_id;
    logic              w_push_en;
    logic              w_pop_en;
    logic              w_pop0;
    logic              w_pop1;
    logic              w_full0;
    logic              w_full1;
    logic              w_empty0;
    logic              w_empty1;
    logic [DATA_W-1:0] w_head0;
    logic [DATA_W-1:0] w_head1;
    logic [1:0]        w_ovf;

    assign w_push_en = r_state == ST_INIT || r_state == ST_IDLE || r_state == ST_ACTIVE;
    assign w_pop_en  = pop && (r_state == ST_IDLE || r_state == ST_ACTIVE);
    // r_last names the lane served most recently; the other lane wins a tie
    assign w_pop0    = w_pop_en && !w_empty0 && (w_empty1 || r_last);
    assign w_pop1    = w_pop_en && !w_empty1 && (w_empty0 || !r_last);
    assign w_ovf[0]  = w_push_en && push0 && w_full0 && !w_pop0;
    assign w_ovf[1]  = w_push_en && push1 && w_full1 && !w_pop1;

    rx_lane_fifo u_lane0 (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push_en && push0),
        .i_pop    (w_pop0),
        .i_data   (data_in0),
        .i_umbral (r_umbral),
        .o_data   (w_head0),
        .o_full   (w_full0),
        .o_empty  (w_empty0),
        .o_pausa  (pausa0)
    );

    rx_lane_fifo u_lane1 (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push_en && push1),
        .i_pop    (w_pop1),
        .i_data   (data_in1),
        .i_umbral (r_umbral),
        .o_data   (w_head1),
        .o_full   (w_full1),
        .o_empty  (w_empty1),
        .o_pausa  (pausa1)
    );

    always_comb begin
        w_next = r_state;
        if (r_state == ST_RESET)
            w_next = ST_INIT;
        else if (r_state != ST_ERROR) begin
            if (|w_ovf)
                w_next = ST_ERROR;
            else if (init)
                w_next = ST_INIT;
            else if (r_state == ST_INIT)
                w_next = ST_IDLE;
            else if (r_state == ST_IDLE && !(w_empty0 && w_empty1))
                w_next = ST_ACTIVE;
            else if (r_state == ST_ACTIVE && w_empty0 && w_empty1 && !r_valid)
                w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RESET;
            r_umbral   <= UMBRAL_DEFAULT;
            r_last     <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
            r_idle     <= 1'b0;
            r_error    <= 1'b0;
            r_error_id <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_active   <= w_next == ST_ACTIVE;
            r_idle     <= w_next == ST_IDLE;
            r_error    <= w_next == ST_ERROR;
            r_error_id <= r_error_id | w_ovf;
            r_valid    <= w_pop0 || w_pop1;
            if (r_state == ST_INIT)
                r_umbral <= umbral;
            if (w_pop0 || w_pop1) begin
                r_data <= w_pop0 ? w_head0 : w_head1;
                r_last <= w_pop1;
            end
        end
    end

    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign active_out = r_active;
    assign idle_out   = r_idle;
    assign error_out  = r_error;
    assign error_id   = r_error_id;
endmodule
